// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if
//   Bundles the PLL lock/restart inputs and the sequenced reset outputs of
//   pll_reset_sequencer.
//   master : sequencer side (consumes PLL_LOCKED/SOFT_RESET, drives resets)
//   slave  : environment side (drives PLL_LOCKED/SOFT_RESET, consumes resets)
//   Signals: PLL_LOCKED, SOFT_RESET, PLL_RESET_N, STAGE_RESET[N_STAGES],
//            READY, SEQ_STATE[2]
//   Optional: PLL_RESET_SEQ_FAULT_COUNT_EN adds FAULT_COUNT[8].
interface pll_reset_sequencer_if #(
    parameter int unsigned N_STAGES = 3
);
    logic                PLL_LOCKED;
    logic                SOFT_RESET;
    logic                PLL_RESET_N;
    logic [N_STAGES-1:0] STAGE_RESET;
    logic                READY;
    logic [1:0]          SEQ_STATE;
`ifdef PLL_RESET_SEQ_FAULT_COUNT_EN
    logic [7:0]          FAULT_COUNT;

    modport master (
        input  PLL_LOCKED, SOFT_RESET,
        output PLL_RESET_N, STAGE_RESET, READY, SEQ_STATE, FAULT_COUNT
    );
    modport slave (
        output PLL_LOCKED, SOFT_RESET,
        input  PLL_RESET_N, STAGE_RESET, READY, SEQ_STATE, FAULT_COUNT
    );
`else
    modport master (
        input  PLL_LOCKED, SOFT_RESET,
        output PLL_RESET_N, STAGE_RESET, READY, SEQ_STATE
    );
    modport slave (
        output PLL_LOCKED, SOFT_RESET,
        input  PLL_RESET_N, STAGE_RESET, READY, SEQ_STATE
    );
`endif
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Lock-aware, restartable power-up sequencer on the 48 MHz oscillator clock.
//   Holds the PLL in reset, filters the synchronised lock flag, then releases
//   the downstream domain resets one stage at a time (bit 0 first). Lock loss,
//   lock timeout or SOFT_RESET re-run the full sequence.
//   Ports:
//     CLK_SLOW     : oscillator clock, sole clock of the block
//     RESET_SLOW_N : asynchronous active-low reset
//     seq          : pll_reset_sequencer_if.master (PLL_LOCKED, SOFT_RESET in;
//                    PLL_RESET_N, STAGE_RESET, READY, SEQ_STATE out)
//   Optional: PLL_RESET_SEQ_FAULT_COUNT_EN adds FAULT_COUNT, an 8-bit
//   saturating count of lock-loss and timeout faults.
module pll_reset_sequencer #(
    parameter int unsigned PLL_HOLD     = 16,
    parameter int unsigned LOCK_FILTER  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned STAGE_DELAY  = 64,
    parameter int unsigned N_STAGES     = 3
) (
    input logic                   CLK_SLOW,
    input logic                   RESET_SLOW_N,
    pll_reset_sequencer_if.master seq
);
    localparam logic [15:0] HOLD_LAST    = 16'(PLL_HOLD - 1);
    localparam logic [15:0] FILTER_LAST  = 16'(LOCK_FILTER - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] DELAY_LAST   = 16'(STAGE_DELAY - 1);
    // Pattern left just before the final stage is released.
    localparam logic [N_STAGES-1:0] LAST_ONE = N_STAGES'(1) << (N_STAGES - 1);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t              state, state_d;
    logic                lock_meta, lock;
    logic                started;
    logic [15:0]         cnt, cnt_d;
    logic [15:0]         tmo, tmo_d;
    logic                pll_reset_n, pll_reset_n_d;
    logic                ready, ready_d;
    logic [N_STAGES-1:0] stage_reset, stage_reset_d;

    logic filter_done, timeout_hit, stage_due, last_stage;
    logic lock_fault, timeout_fault, restart;

    // PLL_LOCKED is asynchronous to CLK_SLOW.
    always_ff @(posedge CLK_SLOW or negedge RESET_SLOW_N) begin
        if (!RESET_SLOW_N) begin
            lock_meta <= 1'b0;
            lock      <= 1'b0;
        end else begin
            lock_meta <= seq.PLL_LOCKED;
            lock      <= lock_meta;
        end
    end

    assign filter_done   = lock && (cnt == FILTER_LAST);
    assign timeout_hit   = (tmo == TIMEOUT_LAST);
    assign stage_due     = (cnt == DELAY_LAST);
    assign last_stage    = (stage_reset == LAST_ONE);
    assign lock_fault    = ((state == RELEASE) || (state == RUN)) && !lock;
    assign timeout_fault = (state == WAIT_LOCK) && timeout_hit && !filter_done;
    // Lock loss takes precedence over a simultaneous SOFT_RESET; both restart.
    assign restart       = lock_fault || timeout_fault ||
                           (seq.SOFT_RESET && (state != HOLD));

    always_ff @(posedge CLK_SLOW or negedge RESET_SLOW_N) begin
        if (!RESET_SLOW_N) state <= HOLD;
        else               state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (restart) begin
            state_d = HOLD;
        end else begin
            unique case (state)
                HOLD:      if (started && (cnt == HOLD_LAST)) state_d = WAIT_LOCK;
                WAIT_LOCK: if (filter_done) state_d = (N_STAGES == 1) ? RUN : RELEASE;
                RELEASE:   if (stage_due && last_stage) state_d = RUN;
                RUN:       state_d = RUN;
            endcase
        end
    end

    // Next values of the registered outputs and counters. Counters clear on
    // every state change; STAGE_RESET shifts left so bit 0 drops first.
    always_comb begin
        cnt_d         = cnt;
        tmo_d         = '0;
        pll_reset_n_d = pll_reset_n;
        stage_reset_d = stage_reset;
        ready_d       = ready;
        if (restart) begin
            cnt_d         = '0;
            pll_reset_n_d = 1'b0;
            stage_reset_d = '1;
            ready_d       = 1'b0;
        end else begin
            unique case (state)
                HOLD: begin
                    if (state_d == WAIT_LOCK) begin
                        cnt_d         = '0;
                        pll_reset_n_d = 1'b1;
                    end else if (started) begin
                        cnt_d = cnt + 16'd1;
                    end
                end
                WAIT_LOCK: begin
                    if (filter_done) begin
                        cnt_d         = '0;
                        stage_reset_d = stage_reset << 1;
                        ready_d       = (state_d == RUN);
                    end else begin
                        cnt_d = lock ? cnt + 16'd1 : '0;
                        tmo_d = tmo + 16'd1;
                    end
                end
                RELEASE: begin
                    if (stage_due) begin
                        cnt_d         = '0;
                        stage_reset_d = stage_reset << 1;
                        ready_d       = (state_d == RUN);
                    end else begin
                        cnt_d = cnt + 16'd1;
                    end
                end
                RUN: begin
                end
            endcase
        end
    end

    // The partial period between reset release and the first edge does not
    // count towards PLL_HOLD, so the HOLD counter starts one edge late.
    always_ff @(posedge CLK_SLOW or negedge RESET_SLOW_N) begin
        if (!RESET_SLOW_N) begin
            started     <= 1'b0;
            cnt         <= '0;
            tmo         <= '0;
            pll_reset_n <= 1'b0;
            stage_reset <= '1;
            ready       <= 1'b0;
        end else begin
            started     <= 1'b1;
            cnt         <= cnt_d;
            tmo         <= tmo_d;
            pll_reset_n <= pll_reset_n_d;
            stage_reset <= stage_reset_d;
            ready       <= ready_d;
        end
    end

    assign seq.PLL_RESET_N = pll_reset_n;
    assign seq.STAGE_RESET = stage_reset;
    assign seq.READY       = ready;
    assign seq.SEQ_STATE   = state;

`ifdef PLL_RESET_SEQ_FAULT_COUNT_EN
    logic [7:0] fault_count;

    always_ff @(posedge CLK_SLOW or negedge RESET_SLOW_N) begin
        if (!RESET_SLOW_N)
            fault_count <= '0;
        else if ((lock_fault || timeout_fault) && (fault_count != 8'hFF))
            fault_count <= fault_count + 8'd1;
    end

    assign seq.FAULT_COUNT = fault_count;
`endif
endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;
    localparam int PLL_HOLD     = 4;
    localparam int LOCK_FILTER  = 8;
    localparam int LOCK_TIMEOUT = 32;
    localparam int STAGE_DELAY  = 4;
    localparam int N_STAGES     = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pll_reset_sequencer_if #(.N_STAGES(N_STAGES)) bus ();

    pll_reset_sequencer #(
        .PLL_HOLD    (PLL_HOLD),
        .LOCK_FILTER (LOCK_FILTER),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STAGE_DELAY (STAGE_DELAY),
        .N_STAGES    (N_STAGES)
    ) dut (
        .CLK_SLOW    (clk),
        .RESET_SLOW_N(rst_n),
        .seq         (bus)
    );

    int passed;
    int checks;

    // Reference model: phase (0 HOLD, 1 WAIT_LOCK, 2 RELEASE, 3 RUN) plus the
    // edge number at which that phase was entered; outputs follow from elapsed
    // edges. Lock seen at edge k is the PLL_LOCKED value sampled at edge k-2.
    int mode;
    int te;
    int e;
    int fault_m;
    bit hist[$];
    int pll_edge, sr0_edge, ready_edge;

    function automatic bit lock_at(input int k);
        return (k >= 2) ? hist[k-2] : 1'b0;
    endfunction

    task automatic model_reset();
        mode = 0; te = 0; e = -1; fault_m = 0;
        hist.delete();
        pll_edge = -1; sr0_edge = -1; ready_edge = -1;
    endtask

    task automatic go_hold(input bit is_fault);
        mode = 0; te = e;
        if (is_fault && fault_m < 255) fault_m++;
    endtask

    task automatic enter(input int m);
        mode = m; te = e;
    endtask

    task automatic model_edge(input bit lk, input bit sf);
        int good;
        bit lck;
        e++;
        hist.push_back(lk);
        lck = lock_at(e);
        case (mode)
            0: if (e - te == PLL_HOLD) enter(1);
            1: begin
                good = 0;
                for (int k = e; k > te; k--) begin
                    if (!lock_at(k)) break;
                    good++;
                end
                if (sf) go_hold((e - te == LOCK_TIMEOUT) && (good != LOCK_FILTER));
                else if (good == LOCK_FILTER) enter((N_STAGES == 1) ? 3 : 2);
                else if (e - te == LOCK_TIMEOUT) go_hold(1'b1);
            end
            2: begin
                if (!lck) go_hold(1'b1);
                else if (sf) go_hold(1'b0);
                else if (e - te == (N_STAGES - 1) * STAGE_DELAY) enter(3);
            end
            default: begin
                if (!lck) go_hold(1'b1);
                else if (sf) go_hold(1'b0);
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s edge=%0d got=%0h expected=%0h", tag, e, got, exp);
    endtask

    task automatic check_outputs();
        logic [N_STAGES-1:0] ones;
        logic [N_STAGES-1:0] sr;
        ones = '1;
        case (mode)
            0, 1:    sr = ones;
            2:       sr = ones << (1 + (e - te) / STAGE_DELAY);
            default: sr = '0;
        endcase
        check("seq_state",   32'(bus.SEQ_STATE),   32'(mode));
        check("pll_reset_n", 32'(bus.PLL_RESET_N), 32'(mode != 0));
        check("stage_reset", 32'(bus.STAGE_RESET), 32'(sr));
        check("ready",       32'(bus.READY),       32'(mode == 3));
`ifdef PLL_RESET_SEQ_FAULT_COUNT_EN
        check("fault_count", 32'(bus.FAULT_COUNT), 32'(fault_m));
`endif
    endtask

    // Called at a negedge: drive inputs, let the edge happen, check at the
    // following negedge.
    task automatic step(input bit lk, input bit sf);
        bus.PLL_LOCKED = lk;
        bus.SOFT_RESET = sf;
        @(posedge clk);
        model_edge(lk, sf);
        @(negedge clk);
        check_outputs();
        if (pll_edge < 0 && bus.PLL_RESET_N === 1'b1) pll_edge = e;
        if (sr0_edge < 0 && bus.STAGE_RESET[0] === 1'b0) sr0_edge = e;
        if (ready_edge < 0 && bus.READY === 1'b1) ready_edge = e;
    endtask

    // Reset asserted between edges must take effect without a clock edge.
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pll_reset_n", 32'(bus.PLL_RESET_N), 32'd0);
        check("async_stage_reset", 32'(bus.STAGE_RESET), 32'h7);
        check("async_ready",       32'(bus.READY),       32'd0);
        check("async_seq_state",   32'(bus.SEQ_STATE),   32'd0);
        @(negedge clk);
        bus.SOFT_RESET = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        passed = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.PLL_LOCKED = 1'b1;
        bus.SOFT_RESET = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Clean start with lock high throughout.
        repeat (24) step(1'b1, 1'b0);
        check("clean_pll_rise_edge", 32'(pll_edge), 32'd4);
        check("clean_sr0_fall_edge", 32'(sr0_edge), 32'd12);
        check("clean_ready_edge",    32'(ready_edge), 32'd20);

        // SOFT_RESET in RUN, then a SOFT_RESET pulse while in HOLD.
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (26) step(1'b1, 1'b0);

        // Lock loss in RUN, then restore.
        repeat (5) step(1'b0, 1'b0);
        repeat (30) step(1'b1, 1'b0);

        // SOFT_RESET coinciding with the lock loss reaching the FSM.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        repeat (30) step(1'b1, 1'b0);

        // One-cycle lock glitch at cycle 9 restarts the filter.
        bus.PLL_LOCKED = 1'b1;
        async_reset();
        repeat (9) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        repeat (30) step(1'b1, 1'b0);
        check("glitch_sr0_fall_edge", 32'(sr0_edge), 32'd19);

        // Lock never asserted: timeouts every 36 cycles.
        bus.PLL_LOCKED = 1'b0;
        async_reset();
        repeat (80) step(1'b0, 1'b0);

        // Reset pulsed mid-RELEASE restarts from cycle 0.
        bus.PLL_LOCKED = 1'b1;
        async_reset();
        repeat (15) step(1'b1, 1'b0);
        async_reset();
        repeat (25) step(1'b1, 1'b0);
        check("restart_ready_edge", 32'(ready_edge), 32'd20);

        // Randomised lock drops and soft restarts.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) async_reset();
            step(($urandom_range(0, 99) < 96), ($urandom_range(0, 99) < 2));
        end

`ifdef PLL_RESET_SEQ_FAULT_COUNT_EN
        // Fault counter saturation.
        bus.PLL_LOCKED = 1'b0;
        async_reset();
        repeat (256 * 36 + 40) step(1'b0, 1'b0);
        check("fault_count_saturated", 32'(bus.FAULT_COUNT), 32'd255);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Power-up and recovery controller for the FPGA clocking resource: the on-chip 48 MHz oscillator clock and the PLL fast clock derived from it. Runs on the slow oscillator clock. Holds the PLL in reset, qualifies its lock signal, then releases the downstream domain resets one stage at a time. Any lock loss or software request re-runs the full sequence. It replaces the free-running power-on reset counters with a lock-aware, restartable sequence.

## Interface
- PLL_HOLD, 16: cycles PLL_RESET_N is held low on each sequence entry (≥1).
- LOCK_FILTER, 1024: consecutive synchronised-lock cycles required before release (≥1).
- LOCK_TIMEOUT, 65535: maximum WAIT_LOCK cycles before retrying the PLL (> LOCK_FILTER).
- STAGE_DELAY, 64: cycles between successive stage releases (≥1).
- N_STAGES, 3: number of sequenced reset outputs (1..8).

- CLK_SLOW  in  1  48 MHz oscillator clock; sole clock of the block.
- RESET_SLOW_N  in  1  asynchronous, active-low reset.
- PLL_LOCKED  in  1  PLL lock flag, asynchronous to CLK_SLOW.
- SOFT_RESET  in  1  synchronous single-cycle restart request.
- PLL_RESET_N  out  1  active-low PLL reset (to PLL RESETB). Reset value 0.
- STAGE_RESET  out  N_STAGES  active-high domain resets; bit 0 released first. Reset value all ones.
- READY  out  1  sequence complete and clocks good. Reset value 0.
- SEQ_STATE  out  2  encoded state: 0 HOLD, 1 WAIT_LOCK, 2 RELEASE, 3 RUN. Reset value 0.

## Operation
- PLL_LOCKED passes through a 2-flop synchroniser. Both flops reset to 0. "lock" means the synchroniser output.
- All outputs are registered. A 16-bit cycle counter and a 16-bit timeout counter are cleared on every state entry.
- HOLD:
  - PLL_RESET_N=0, STAGE_RESET all 1, READY=0.
  - After PLL_HOLD cycles, go to WAIT_LOCK and set PLL_RESET_N=1.
- WAIT_LOCK:
  - The counter increments while lock=1 and clears to 0 when lock=0.
  - When it reaches LOCK_FILTER, go to RELEASE and clear STAGE_RESET[0] on that edge.
  - If the timeout counter reaches LOCK_TIMEOUT first, go to HOLD (timeout fault).
- RELEASE:
  - Every STAGE_DELAY cycles, clear the next STAGE_RESET bit in ascending order.
  - The edge that clears bit N_STAGES-1 also sets READY=1 and enters RUN.
  - With N_STAGES=1, WAIT_LOCK goes directly to RUN: bit 0 clears and READY sets on the same edge.
- RUN: hold all outputs steady.
- Lock loss:
  - lock=0 in RELEASE or RUN is a lock-loss fault.
  - Next edge: STAGE_RESET all 1, READY=0, PLL_RESET_N=0, state HOLD.
- SOFT_RESET=1 in WAIT_LOCK, RELEASE or RUN: same response as lock loss, but it is not a fault. SOFT_RESET is ignored in HOLD; the HOLD count is not restarted.
- SOFT_RESET and lock loss in the same cycle: treated as a single lock-loss fault.
- RESET_SLOW_N low at any time forces reset values immediately, regardless of CLK_SLOW.

## Timing
- First rising edge after RESET_SLOW_N deasserts is cycle 0. PLL_RESET_N rises at edge PLL_HOLD.
- Lock-input latency: a PLL_LOCKED transition is visible as lock 2 edges later. Lock loss reaches STAGE_RESET/READY on the 3rd edge after the PLL_LOCKED fall.
- With lock stable high:
  - STAGE_RESET[0] falls LOCK_FILTER cycles after PLL_RESET_N rises.
  - Bit k falls k·STAGE_DELAY cycles after bit 0.
  - READY rises together with the last bit.
- Reset assertion is all bits simultaneously. Release is never simultaneous for N_STAGES>1.
- Counters never wrap. Parameters are bounded to 16 bits.

## Configuration
- PLL_RESET_SEQ_FAULT_COUNT_EN defined:
  - Adds output FAULT_COUNT (out, 8), an 8-bit saturating count of lock-loss and timeout faults.
  - Reset value 0. Increments once per fault and saturates at 255. SOFT_RESET does not increment it.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
All scenarios use PLL_HOLD=4, LOCK_FILTER=8, LOCK_TIMEOUT=32, STAGE_DELAY=4, N_STAGES=3.
- Clean start, PLL_LOCKED high throughout -> PLL_RESET_N rises at cycle 4. STAGE_RESET 3'b110 at 12, 3'b100 at 16, 3'b000 and READY=1 at 20. SEQ_STATE 0→1→2→3.
- Lock glitch: PLL_LOCKED low for 1 cycle at cycle 9 -> the filter restarts and STAGE_RESET[0] falls 8 cycles after lock returns high, not at 12.
- PLL_LOCKED never high -> at cycle 36 state returns to HOLD and PLL_RESET_N=0. Retries repeat every 36 cycles. FAULT_COUNT increments per retry (macro on).
- In RUN, drop PLL_LOCKED -> 3 edges later STAGE_RESET=3'b111, READY=0, PLL_RESET_N=0. Restoring lock re-runs the full sequence. FAULT_COUNT=1.
- SOFT_RESET pulse in RUN -> HOLD next edge, full re-sequence, FAULT_COUNT unchanged. A SOFT_RESET pulse during HOLD has no effect on timing.
- RESET_SLOW_N pulsed low mid-RELEASE -> outputs return to reset values asynchronously, and the sequence restarts from cycle 0 on deassertion.
